// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised rx, internal baud tick, mid-bit sampling,
// start-glitch rejection and separate parity, framing and break reporting.
module uart_rx_os #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "none",
    parameter int    STOP_BITS  = 1,
    parameter int    OVERSAMPLE = 16,
    parameter int    DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    output logic                 rx_parity_error,
    output logic                 rx_frame_error,
    output logic                 rx_break,
    output logic                 rx_busy
);
    localparam bit HAS_PAR = (PARITY_BIT != "none");
    localparam bit PAR_ODD = (PARITY_BIT == "odd");
    localparam int BC_MAX  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BC_W    = $clog2(BC_MAX + 1);
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_END    = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

    // state | meaning: IDLE line idle | START confirm start at mid-bit | DATA, PARITY, STOP
    // sample one bit per OVERSAMPLE ticks | WAIT_HIGH hold until a low line is released
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_latched;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] frame;
    logic                 par_bit;
    logic                 stop_err;
    logic                 stop_one;
    logic                 tick;
    logic                 sample_pt;
    logic                 stop_err_n;
    logic                 stop_one_n;
    logic                 par_bad;
    logic                 is_break;

    assign rx_s       = sync[1];
    assign tick       = (div_cnt == div_latched);
    assign sample_pt  = tick && (os_cnt == OS_END);
    assign stop_err_n = stop_err | ~rx_s;
    assign stop_one_n = stop_one | rx_s;
    assign par_bad    = HAS_PAR && (par_bit != ((^frame) ^ PAR_ODD));
    assign is_break   = (frame == '0) && !(HAS_PAR && par_bit) && !stop_one_n;
    assign rx_busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            div_cnt         <= '0;
            div_latched     <= '0;
            os_cnt          <= '0;
            bit_cnt         <= '0;
            frame           <= '0;
            par_bit         <= 1'b0;
            stop_err        <= 1'b0;
            stop_one        <= 1'b0;
            rx_data         <= '0;
            rx_data_valid   <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_frame_error  <= 1'b0;
            rx_break        <= 1'b0;
        end else begin
            rx_data_valid   <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_frame_error  <= 1'b0;
            rx_break        <= 1'b0;
            if (state != IDLE && state != WAIT_HIGH)
                div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
            // After the start bit, os_cnt wraps once per bit so samples stay at mid-bit.
            if ((state == DATA || state == PARITY || state == STOP) && tick)
                os_cnt <= sample_pt ? '0 : os_cnt + OS_W'(1);
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    os_cnt  <= '0;
                    if (!rx_s) begin
                        div_latched <= baud_div;
                        state       <= START;
                    end
                end
                START: if (tick) begin
                    if (os_cnt == OS_MID) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            os_cnt   <= '0;
                            bit_cnt  <= '0;
                            stop_err <= 1'b0;
                            stop_one <= 1'b0;
                            state    <= DATA;
                        end
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                DATA: if (sample_pt) begin
                    frame <= {rx_s, frame[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        state   <= HAS_PAR ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                PARITY: if (sample_pt) begin
                    par_bit <= rx_s;
                    bit_cnt <= '0;
                    state   <= STOP;
                end
                STOP: if (sample_pt) begin
                    stop_err <= stop_err_n;
                    stop_one <= stop_one_n;
                    if (bit_cnt != STOP_LAST) begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end else if (is_break) begin
                        rx_break <= 1'b1;
                        state    <= WAIT_HIGH;
                    end else if (stop_err_n) begin
                        rx_frame_error  <= 1'b1;
                        rx_parity_error <= par_bad;
                        state           <= WAIT_HIGH;
                    end else if (par_bad) begin
                        rx_parity_error <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        rx_data       <= frame;
                        rx_data_valid <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
